lif_param_loader: RTL and testbench

LIF_PARAM_LOADER -- requirements
Module: lif_param_loader

---
 rtl/lif_pkg.sv | 18 +
 rtl/lif_timeout_ctr.sv | 25 ++
 rtl/lif_param_loader.sv | 135 +++++++++++++
 tb/tb_lif_param_loader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// Shared definitions for the LIF neuron parameter loader.
// Holds the loader FSM states, the frame length and the parameter field widths.
package lif_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StReady,
        StError
    } lif_state_e;

    localparam int unsigned FRAME_BYTES   = 5;
    localparam int unsigned W_WEIGHT      = 3;
    localparam int unsigned W_LEAK_RATE   = 8;
    localparam int unsigned W_THRESHOLD   = 8;
    localparam int unsigned W_LEAK_CYCLES = 4;

endpackage

// File: rtl/lif_timeout_ctr.sv
// Idle-cycle counter for the parameter loader.
// expired fires on the counted cycle that brings the idle count up to LIMIT.
module lif_timeout_ctr #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    logic [7:0] count_q;

    assign expired = count_en && !clear && (count_q == 8'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (count_en) begin
            count_q <= count_q + 8'd1;
        end
    end

endmodule

// File: rtl/lif_param_loader.sv
// Serial loader for LIF neuron parameters: a 5-byte frame with an XOR checksum
// is staged byte by byte and committed to the outputs only when the checksum matches.
module lif_param_loader
    import lif_pkg::*;
#(
    parameter int unsigned                TIMEOUT_CYCLES  = 255,
    parameter logic [W_WEIGHT-1:0]        DEF_WEIGHT      = 3'd1,
    parameter logic [W_LEAK_RATE-1:0]     DEF_LEAK_RATE   = 8'd1,
    parameter logic [W_THRESHOLD-1:0]     DEF_THRESHOLD   = 8'd64,
    parameter logic [W_LEAK_CYCLES-1:0]   DEF_LEAK_CYCLES = 4'd3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_start,
    input  logic [7:0]               data_in,
    input  logic                     data_valid,
    output logic [W_WEIGHT-1:0]      weight_a,
    output logic [W_LEAK_RATE-1:0]   leak_rate,
    output logic [W_THRESHOLD-1:0]   threshold,
    output logic [W_LEAK_CYCLES-1:0] leak_cycles,
    output logic                     params_ready,
    output logic                     busy,
    output logic                     load_error
);

    localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);

    lif_state_e state_q, state_d;

    logic [2:0]               idx_q;
    logic [7:0]               xor_q;
    logic [W_WEIGHT-1:0]      stage_w_q;
    logic [W_LEAK_RATE-1:0]   stage_lr_q;
    logic [W_THRESHOLD-1:0]   stage_th_q;
    logic [W_LEAK_CYCLES-1:0] stage_lc_q;

    logic accept, last_byte, commit;
    logic tmo_clear, tmo_en, tmo_expired;
    logic busy_d, params_ready_d, load_error_d;

    // load_start always wins over a byte arriving on the same cycle.
    assign accept    = (state_q == StLoad) && data_valid && !load_start;
    assign last_byte = accept && (idx_q == LAST_IDX);
    assign commit    = last_byte && (data_in == xor_q);

    assign tmo_clear = load_start || data_valid || (state_q != StLoad);
    assign tmo_en    = (state_q == StLoad) && !data_valid && !load_start;

    lif_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk      (clk),
        .reset    (reset),
        .clear    (tmo_clear),
        .count_en (tmo_en),
        .expired  (tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load_start) begin
            state_d = StLoad;
        end else if (state_q == StLoad) begin
            if (last_byte) begin
                state_d = commit ? StReady : StError;
            end else if (tmo_expired) begin
                state_d = StError;
            end
        end
    end

    always_comb begin
        busy_d         = (state_d == StLoad);
        params_ready_d = (state_d == StReady);
        load_error_d   = (state_d == StError);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy         <= 1'b0;
            params_ready <= 1'b0;
            load_error   <= 1'b0;
        end else begin
            busy         <= busy_d;
            params_ready <= params_ready_d;
            load_error   <= load_error_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q      <= '0;
            xor_q      <= '0;
            stage_w_q  <= '0;
            stage_lr_q <= '0;
            stage_th_q <= '0;
            stage_lc_q <= '0;
        end else if (load_start) begin
            idx_q <= '0;
            xor_q <= '0;
        end else if (accept && !last_byte) begin
            idx_q <= idx_q + 3'd1;
            xor_q <= xor_q ^ data_in;
            case (idx_q)
                3'd0:    stage_w_q  <= data_in[W_WEIGHT-1:0];
                3'd1:    stage_lr_q <= data_in;
                3'd2:    stage_th_q <= data_in;
                default: stage_lc_q <= data_in[W_LEAK_CYCLES-1:0];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            weight_a    <= DEF_WEIGHT;
            leak_rate   <= DEF_LEAK_RATE;
            threshold   <= DEF_THRESHOLD;
            leak_cycles <= DEF_LEAK_CYCLES;
        end else if (commit) begin
            weight_a    <= stage_w_q;
            leak_rate   <= stage_lr_q;
            threshold   <= stage_th_q;
            leak_cycles <= stage_lc_q;
        end
    end

endmodule

// File: tb/tb_lif_param_loader.sv
// Bench for lif_param_loader: directed scenarios plus random traffic, all checked
// against a frame-level reference model kept in the bench.
module tb_lif_param_loader;

    localparam int TMO = 255;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load_start = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic [2:0] weight_a;
    logic [7:0] leak_rate;
    logic [7:0] threshold;
    logic [3:0] leak_cycles;
    logic       params_ready;
    logic       busy;
    logic       load_error;

    lif_param_loader dut (
        .clk          (clk),
        .reset        (reset),
        .load_start   (load_start),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .weight_a     (weight_a),
        .leak_rate    (leak_rate),
        .threshold    (threshold),
        .leak_cycles  (leak_cycles),
        .params_ready (params_ready),
        .busy         (busy),
        .load_error   (load_error)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: 0 idle, 1 loading, 2 ready, 3 error.
    int         m_mode = 0;
    logic [7:0] m_bytes[$];
    int         m_idle = 0;
    logic [2:0] m_w  = 3'd1;
    logic [7:0] m_lr = 8'd1;
    logic [7:0] m_th = 8'd64;
    logic [3:0] m_lc = 4'd3;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_update(input logic r, input logic ls, input logic dv,
                                         input logic [7:0] d);
        logic [7:0] x;
        if (r) begin
            m_mode = 0; m_bytes.delete(); m_idle = 0;
            m_w = 3'd1; m_lr = 8'd1; m_th = 8'd64; m_lc = 4'd3;
        end else if (ls) begin
            m_mode = 1; m_bytes.delete(); m_idle = 0;
        end else if (m_mode == 1) begin
            if (dv) begin
                m_idle = 0;
                if (m_bytes.size() < 4) begin
                    m_bytes.push_back(d);
                end else begin
                    x = m_bytes[0] ^ m_bytes[1] ^ m_bytes[2] ^ m_bytes[3];
                    if (d == x) begin
                        m_w  = m_bytes[0][2:0];
                        m_lr = m_bytes[1];
                        m_th = m_bytes[2];
                        m_lc = m_bytes[3][3:0];
                        m_mode = 2;
                    end else begin
                        m_mode = 3;
                    end
                end
            end else begin
                m_idle++;
                if (m_idle == TMO) m_mode = 3;
            end
        end
    endfunction

    task automatic check_model(input string tag);
        check_eq({tag, ".weight"}, weight_a, m_w);
        check_eq({tag, ".leak"}, leak_rate, m_lr);
        check_eq({tag, ".thr"}, threshold, m_th);
        check_eq({tag, ".lcyc"}, leak_cycles, m_lc);
        check_eq({tag, ".ready"}, params_ready, m_mode == 2);
        check_eq({tag, ".busy"}, busy, m_mode == 1);
        check_eq({tag, ".err"}, load_error, m_mode == 3);
    endtask

    task automatic step(input string tag, input logic r, input logic ls, input logic dv,
                        input logic [7:0] d);
        reset = r; load_start = ls; data_valid = dv; data_in = d;
        @(posedge clk);
        model_update(r, ls, dv, d);
        #1;
        check_model(tag);
        reset = 1'b0; load_start = 1'b0; data_valid = 1'b0; data_in = 8'h00;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_ref_frame(input string tag, input logic [7:0] csum);
        logic [7:0] f[5];
        f[0] = 8'h05; f[1] = 8'h02; f[2] = 8'h30; f[3] = 8'h03; f[4] = csum;
        step(tag, 1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) step(tag, 1'b0, 1'b0, 1'b1, f[i]);
    endtask

    task automatic rand_frame(input bit good);
        logic [7:0] f[5];
        for (int i = 0; i < 4; i++) f[i] = 8'($urandom);
        f[4] = f[0] ^ f[1] ^ f[2] ^ f[3];
        if (!good) f[4] = f[4] ^ 8'($urandom_range(1, 255));
        step("rf", 1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            idle("rf_gap", $urandom_range(0, 3));
            step("rf", 1'b0, 1'b0, 1'b1, f[i]);
        end
    endtask

    initial begin
        // Reset and defaults.
        step("rst", 1'b1, 1'b0, 1'b0, 8'h00);
        step("rst", 1'b1, 1'b1, 1'b1, 8'hFF);
        idle("idle10", 10);
        check_eq("def_weight", weight_a, 3'd1);
        check_eq("def_leak", leak_rate, 8'd1);
        check_eq("def_thr", threshold, 8'd64);
        check_eq("def_lcyc", leak_cycles, 4'd3);
        check_eq("def_ready", params_ready, 1'b0);
        check_eq("def_busy", busy, 1'b0);

        // Stray byte while idle is ignored.
        step("idle_dv", 1'b0, 1'b0, 1'b1, 8'h77);

        // Good frame.
        send_ref_frame("good", 8'h34);
        check_eq("good_weight", weight_a, 3'd5);
        check_eq("good_leak", leak_rate, 8'h02);
        check_eq("good_thr", threshold, 8'h30);
        check_eq("good_lcyc", leak_cycles, 4'd3);
        check_eq("good_ready", params_ready, 1'b1);
        check_eq("good_err", load_error, 1'b0);
        idle("ready_hold", 3);

        // Bad checksum keeps the committed set.
        send_ref_frame("badck", 8'h35);
        check_eq("badck_err", load_error, 1'b1);
        check_eq("badck_ready", params_ready, 1'b0);
        check_eq("badck_weight", weight_a, 3'd5);
        check_eq("badck_thr", threshold, 8'h30);

        // Timeout after two bytes.
        step("tmo", 1'b0, 1'b1, 1'b0, 8'h00);
        step("tmo", 1'b0, 1'b0, 1'b1, 8'h11);
        step("tmo", 1'b0, 1'b0, 1'b1, 8'h22);
        idle("tmo_wait", TMO - 1);
        check_eq("tmo_busy_before", busy, 1'b1);
        idle("tmo_last", 1);
        check_eq("tmo_err", load_error, 1'b1);
        check_eq("tmo_busy", busy, 1'b0);
        step("tmo_stray", 1'b0, 1'b0, 1'b1, 8'h5A);
        check_eq("tmo_stray_err", load_error, 1'b1);

        // load_start together with data_valid drops the byte and restarts.
        step("lsdv_rst", 1'b1, 1'b0, 1'b0, 8'h00);
        step("lsdv", 1'b0, 1'b1, 1'b0, 8'h00);
        step("lsdv", 1'b0, 1'b0, 1'b1, 8'h07);
        step("lsdv", 1'b0, 1'b0, 1'b1, 8'h09);
        step("lsdv_both", 1'b0, 1'b1, 1'b1, 8'hAA);
        for (int i = 0; i < 5; i++) begin
            logic [7:0] fb[5];
            fb[0] = 8'h05; fb[1] = 8'h02; fb[2] = 8'h30; fb[3] = 8'h03; fb[4] = 8'h34;
            step("lsdv_frame", 1'b0, 1'b0, 1'b1, fb[i]);
        end
        check_eq("lsdv_weight", weight_a, 3'd5);
        check_eq("lsdv_leak", leak_rate, 8'h02);
        check_eq("lsdv_ready", params_ready, 1'b1);

        // Reset mid-load.
        step("midrst", 1'b0, 1'b1, 1'b0, 8'h00);
        step("midrst", 1'b0, 1'b0, 1'b1, 8'h06);
        step("midrst", 1'b0, 1'b0, 1'b1, 8'h40);
        step("midrst", 1'b0, 1'b0, 1'b1, 8'h20);
        step("midrst_r", 1'b1, 1'b0, 1'b1, 8'h0F);
        step("midrst_tail", 1'b0, 1'b0, 1'b1, 8'h69);
        check_eq("midrst_weight", weight_a, 3'd1);
        check_eq("midrst_thr", threshold, 8'd64);
        check_eq("midrst_ready", params_ready, 1'b0);
        check_eq("midrst_busy", busy, 1'b0);

        // Random traffic.
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: rand_frame(1'b1);
                1: rand_frame(1'b0);
                2: for (int c = 0; c < 50; c++)
                    step("chaos", ($urandom_range(0, 99) == 0), ($urandom_range(0, 29) == 0),
                         $urandom_range(0, 1) == 1, 8'($urandom));
                default: begin
                    step("long", 1'b0, 1'b1, 1'b0, 8'h00);
                    step("long", 1'b0, 1'b0, 1'b1, 8'($urandom));
                    idle("long_idle", $urandom_range(TMO - 5, TMO + 5));
                end
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
